// File: rtl/pc_gen_unit.sv
// ============================================================================
// pc_gen_unit : fetch-stage PC generator with valid/ready issue, EX redirects
//               and an optional direct-mapped BTB (enable with PC_BTB_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen_unit #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               BTB_ENTRIES  = 16,
    parameter int               BTB_TAG_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    input  logic            redir_valid,
    input  logic [1:0]      redir_kind,
    input  logic            redir_taken,
    input  logic [XLEN-1:0] redir_src_pc,
    input  logic [XLEN-1:0] redir_imm,
    input  logic [XLEN-1:0] redir_rs1,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_JALR   = 2'b10;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc_next;
    logic            pred_next;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_seq;
    logic            btb_hit;
    logic            redir_fire;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] jalr_sum;
    logic            target_misaligned;

    // Illegal configurations elaborate a marker block so they are easy to spot.
    generate
        if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0 ||
            BTB_TAG_W < 1 || RESET_VECTOR[1:0] != 2'b00) begin : g_bad_config
        end
    endgenerate

    assign pc_plus4   = pc + XLEN'(4);
    assign redir_fire = redir_valid && (redir_kind != 2'b11);
    assign jalr_sum   = redir_rs1 + redir_imm;

    always_comb begin
        redir_target = redir_src_pc + XLEN'(4);
        case (redir_kind)
            KIND_BRANCH: redir_target = redir_taken ? (redir_src_pc + redir_imm)
                                                    : (redir_src_pc + XLEN'(4));
            KIND_JAL:    redir_target = redir_src_pc + redir_imm;
            KIND_JALR:   redir_target = jalr_sum & ~XLEN'(1);
            default:     redir_target = redir_src_pc + XLEN'(4);
        endcase
    end

    assign target_misaligned = redir_target[1];

`ifdef PC_BTB_EN
    localparam int IDX_W  = $clog2(BTB_ENTRIES);
    localparam int TAG_LO = IDX_W + 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_TAG_W-1:0]   btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

    logic [IDX_W-1:0]       pc_idx;
    logic [BTB_TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]       src_idx;
    logic [BTB_TAG_W-1:0]   src_tag;
    logic                   src_hit;
    logic                   btb_install;
    logic                   btb_invalidate;

    assign pc_idx  = pc[IDX_W+1:2];
    assign pc_tag  = pc[TAG_LO +: BTB_TAG_W];
    assign src_idx = redir_src_pc[IDX_W+1:2];
    assign src_tag = redir_src_pc[TAG_LO +: BTB_TAG_W];

    assign btb_hit  = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);
    assign src_hit  = btb_valid[src_idx] && (btb_tag[src_idx] == src_tag);
    assign next_seq = btb_hit ? btb_target[pc_idx] : pc_plus4;

    // Misaligned targets never touch the BTB; JALR targets are data dependent.
    assign btb_install    = redir_fire && !target_misaligned &&
                            ((redir_kind == KIND_BRANCH && redir_taken) ||
                             (redir_kind == KIND_JAL));
    assign btb_invalidate = redir_fire && !target_misaligned &&
                            (redir_kind == KIND_BRANCH) && !redir_taken && src_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid <= '0;
        end else if (btb_install) begin
            btb_valid[src_idx] <= 1'b1;
        end else if (btb_invalidate) begin
            btb_valid[src_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_install) begin
            btb_tag[src_idx]    <= src_tag;
            btb_target[src_idx] <= redir_target;
        end
    end
`else
    assign btb_hit  = 1'b0;
    assign next_seq = pc_plus4;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            pred_taken <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pred_taken <= pred_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        pred_next  = pred_taken;
        if (redir_fire) begin
            pc_next    = redir_target;
            pred_next  = 1'b0;
            state_next = target_misaligned ? ERR : RUN;
        end else begin
            case (state)
                BOOT:  state_next = RUN;
                RUN: begin
                    if (stall) begin
                        state_next = STALL;
                    end else if (fetch_ready) begin
                        pc_next   = next_seq;
                        pred_next = btb_hit;
                    end
                end
                STALL: if (!stall) state_next = RUN;
                ERR:   state_next = ERR;
                default: state_next = BOOT;
            endcase
        end
    end

    assign fetch_valid  = (state == RUN);
    assign misalign_err = (state == ERR);

endmodule

`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit; BTB scenario runs when PC_BTB_EN is defined.
`default_nettype none

module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic        redir_taken;
    logic [31:0] redir_src_pc;
    logic [31:0] redir_imm;
    logic [31:0] redir_rs1;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .BTB_ENTRIES(16), .BTB_TAG_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc(pc), .pred_taken(pred_taken),
        .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_taken(redir_taken),
        .redir_src_pc(redir_src_pc), .redir_imm(redir_imm), .redir_rs1(redir_rs1),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_redir(input logic [1:0] kind, input logic taken,
                               input logic [31:0] src, input logic [31:0] imm,
                               input logic [31:0] rs1);
        redir_valid = 1'b1; redir_kind = kind; redir_taken = taken;
        redir_src_pc = src; redir_imm = imm; redir_rs1 = rs1;
    endtask

    task automatic clear_redir();
        redir_valid = 1'b0; redir_kind = 2'b00; redir_taken = 1'b0;
        redir_src_pc = '0; redir_imm = '0; redir_rs1 = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4];
        reset = 1'b0; stall = 1'b0; fetch_ready = 1'b1; clear_redir();
        tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", misalign_err); end
        reset = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL boot_cycle: fv=%b pc=%h want fv=0 pc=0", fetch_valid, pc); end
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i] || fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fetch%0d: pc=%h fv=%b want pc=%h fv=1", i, pc, fetch_valid, exp_pc[i]); end
        end
    endtask

    task automatic test_ready_hold();
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL reach_10: got %h want 10", pc); end
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h10 || fetch_valid !== 1'b1) begin errors++; $display("FAIL ready_hold%0d: pc=%h fv=%b want pc=10 fv=1", i, pc, fetch_valid); end
        end
        fetch_ready = 1'b1;
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL ready_release: got %h want 14", pc); end
    endtask

    task automatic test_stall();
        tick(); tick(); tick();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL reach_20: got %h want 20", pc); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h20 || fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: pc=%h fv=%b want pc=20 fv=0", i, pc, fetch_valid); end
        end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h20 || fetch_valid !== 1'b1) begin errors++; $display("FAIL stall_resume: pc=%h fv=%b want pc=20 fv=1", pc, fetch_valid); end
        tick();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL stall_advance: got %h want 24", pc); end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        tick();
        drive_redir(2'b10, 1'b0, 32'h40, 32'h4, 32'h101);
        tick();
        clear_redir(); stall = 1'b0;
        checks++; if (pc !== 32'h104 || fetch_valid !== 1'b1 || pred_taken !== 1'b0) begin errors++; $display("FAIL jalr_in_stall: pc=%h fv=%b pred=%b want pc=104 fv=1 pred=0", pc, fetch_valid, pred_taken); end
        drive_redir(2'b00, 1'b1, 32'hFFFF_FFFC, 32'h8, 32'h0);
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL branch_wrap: got %h want 4", pc); end
        drive_redir(2'b00, 1'b0, 32'h30, 32'h100, 32'h0);
        tick();
        checks++; if (pc !== 32'h34) begin errors++; $display("FAIL branch_not_taken: got %h want 34", pc); end
        drive_redir(2'b11, 1'b1, 32'h500, 32'h40, 32'h0);
        tick();
        checks++; if (pc !== 32'h38) begin errors++; $display("FAIL reserved_kind: got %h want 38", pc); end
    endtask

    task automatic test_back_to_back();
        drive_redir(2'b01, 1'b0, 32'h0, 32'h200, 32'h0);
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL b2b_first: got %h want 200", pc); end
        drive_redir(2'b01, 1'b0, 32'h300, 32'h10, 32'h0);
        tick();
        checks++; if (pc !== 32'h310 || fetch_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: pc=%h fv=%b want pc=310 fv=1", pc, fetch_valid); end
        clear_redir();
    endtask

    task automatic test_misalign();
        drive_redir(2'b01, 1'b0, 32'h50, 32'h6, 32'h0);
        tick();
        clear_redir();
        checks++; if (pc !== 32'h56 || misalign_err !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL misalign_enter: pc=%h err=%b fv=%b want pc=56 err=1 fv=0", pc, misalign_err, fetch_valid); end
        tick();
        checks++; if (pc !== 32'h56 || misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_hold: pc=%h err=%b want pc=56 err=1", pc, misalign_err); end
        drive_redir(2'b01, 1'b0, 32'h0, 32'h80, 32'h0);
        tick();
        checks++; if (pc !== 32'h80 || misalign_err !== 1'b0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL misalign_exit: pc=%h err=%b fv=%b want pc=80 err=0 fv=1", pc, misalign_err, fetch_valid); end
        drive_redir(2'b10, 1'b0, 32'h0, 32'h0, 32'h201);
        tick();
        clear_redir();
        checks++; if (pc !== 32'h200 || misalign_err !== 1'b0) begin errors++; $display("FAIL jalr_bit0: pc=%h err=%b want pc=200 err=0", pc, misalign_err); end
        tick();
        checks++; if (pc !== 32'h204) begin errors++; $display("FAIL after_jalr: got %h want 204", pc); end
    endtask

    // Steer fetch to 0xFC via a not-taken branch at 0xF8 and step onto 0x100.
    task automatic walk_to_100();
        drive_redir(2'b00, 1'b0, 32'hF8, 32'h0, 32'h0);
        tick();
        clear_redir();
        tick();
    endtask

    task automatic test_btb();
        drive_redir(2'b00, 1'b1, 32'h100, 32'h40, 32'h0);
        tick();
        checks++; if (pc !== 32'h140 || pred_taken !== 1'b0) begin errors++; $display("FAIL btb_train: pc=%h pred=%b want pc=140 pred=0", pc, pred_taken); end
        walk_to_100();
        checks++; if (pc !== 32'h100 || pred_taken !== 1'b0) begin errors++; $display("FAIL btb_reach: pc=%h pred=%b want pc=100 pred=0", pc, pred_taken); end
        tick();
`ifdef PC_BTB_EN
        checks++; if (pc !== 32'h140 || pred_taken !== 1'b1) begin errors++; $display("FAIL btb_hit: pc=%h pred=%b want pc=140 pred=1", pc, pred_taken); end
        tick();
        checks++; if (pc !== 32'h144 || pred_taken !== 1'b0) begin errors++; $display("FAIL btb_after_hit: pc=%h pred=%b want pc=144 pred=0", pc, pred_taken); end
        drive_redir(2'b00, 1'b0, 32'h100, 32'h40, 32'h0);
        tick();
        clear_redir();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL btb_nt_redirect: got %h want 104", pc); end
        walk_to_100();
        tick();
        checks++; if (pc !== 32'h104 || pred_taken !== 1'b0) begin errors++; $display("FAIL btb_invalidated: pc=%h pred=%b want pc=104 pred=0", pc, pred_taken); end
        drive_redir(2'b00, 1'b1, 32'h100, 32'h40, 32'h0);
        tick();
        clear_redir();
`else
        checks++; if (pc !== 32'h104 || pred_taken !== 1'b0) begin errors++; $display("FAIL no_btb_seq: pc=%h pred=%b want pc=104 pred=0", pc, pred_taken); end
`endif
    endtask

    task automatic test_reset_midop();
        reset = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b0 || pred_taken !== 1'b0) begin errors++; $display("FAIL async_reset: pc=%h fv=%b pred=%b want pc=0 fv=0 pred=0", pc, fetch_valid, pred_taken); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL reboot: pc=%h fv=%b want pc=0 fv=1", pc, fetch_valid); end
        walk_to_100();
        tick();
        checks++; if (pc !== 32'h104 || pred_taken !== 1'b0) begin errors++; $display("FAIL btb_cleared_by_reset: pc=%h pred=%b want pc=104 pred=0", pc, pred_taken); end
    endtask

    initial begin
        test_reset();
        test_ready_hold();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_misalign();
        test_btb();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
